// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: captures an 8-bit RGB565 camera stream (two bytes per pixel,
// high byte first), converts each pixel to RGB444 and issues frame-buffer writes.
//
// Parameters:
//   H_ACTIVE - pixels per active line
//   V_ACTIVE - active lines per frame
//   ADDR_W   - frame-buffer address width
//
// Ports:
//   pclk       - camera pixel clock; everything runs on its rising edge
//   rst        - synchronous, active-high reset
//   vsync      - frame sync, high between frames
//   href       - line valid, high during active bytes
//   d          - camera data byte
//   addr       - frame-buffer write address
//   dout       - RGB444 pixel {R[3:0], G[3:0], B[3:0]}
//   we         - one-cycle write strobe qualifying addr/dout
//   frame_done - one-cycle pulse on each vsync rise (not the first after reset)
//   overflow   - sticky; a frame supplied more pixels than the buffer holds
//
// Build option:
//   RGB_FRAME_WRITER_DECIMATE_EN - when defined, only even pixels of even lines are
//   written and the buffer is sized (H_ACTIVE/2)*(V_ACTIVE/2).

module rgb_frame_writer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              overflow
);

`ifdef RGB_FRAME_WRITER_DECIMATE_EN
  localparam int unsigned FrameSize = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int unsigned FrameSize = H_ACTIVE * V_ACTIVE;
`endif
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FrameSize - 1);

  typedef enum logic [1:0] {StSync, StIdle, StHi, StLo} state_e;

  state_e            state_q, state_d;
  logic              vs_q, vs_prev_q, hr_q;
  logic [7:0]        d_q, hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       dout_q;
  logic              we_q, frame_done_q, overflow_q;
  logic              full_q;       // last location has been written this frame
  logic              seen_rise_q;  // first vsync rise after reset already passed

  logic vs_rise, vs_fall;
  logic latch_hi, pix_done;
  logic keep, at_last, wr_fire, ovf_fire;

  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;

  // Next-state logic. HI behaves like IDLE; both wait for the next high byte.
  always_comb begin
    state_d  = state_q;
    latch_hi = 1'b0;
    pix_done = 1'b0;
    if (vs_q) begin
      state_d = StSync;
    end else begin
      unique case (state_q)
        StSync: begin
          if (vs_fall) state_d = StIdle;
        end
        StIdle, StHi: begin
          if (hr_q) begin
            latch_hi = 1'b1;
            state_d  = StLo;
          end else begin
            state_d = StIdle;
          end
        end
        StLo: begin
          // href low here means the line ended on a lone high byte: drop it.
          if (hr_q) begin
            pix_done = 1'b1;
            state_d  = StHi;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

`ifdef RGB_FRAME_WRITER_DECIMATE_EN
  logic hr_prev_q, line_odd_q, pix_odd_q;
  logic line_end;

  assign line_end = hr_prev_q & ~hr_q;
  assign keep     = ~line_odd_q & ~pix_odd_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      hr_prev_q  <= 1'b0;
      line_odd_q <= 1'b0;
      pix_odd_q  <= 1'b0;
    end else begin
      hr_prev_q <= hr_q;
      if (state_q == StSync) begin
        line_odd_q <= 1'b0;
        pix_odd_q  <= 1'b0;
      end else if (line_end) begin
        line_odd_q <= ~line_odd_q;
        pix_odd_q  <= 1'b0;
      end else if (pix_done) begin
        pix_odd_q <= ~pix_odd_q;
      end
    end
  end
`else
  assign keep = 1'b1;
`endif

  // The write at LastAddr is still in flight while full_q lags by a cycle.
  assign at_last  = full_q | (we_q & (addr_q == LastAddr));
  assign wr_fire  = pix_done & keep & ~at_last;
  assign ovf_fire = pix_done & keep & at_last;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= StSync;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      hr_q         <= 1'b0;
      d_q          <= 8'h00;
      hi_q         <= 8'h00;
      addr_q       <= '0;
      dout_q       <= 12'h000;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      full_q       <= 1'b0;
      seen_rise_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vsync;
      vs_prev_q    <= vs_q;
      hr_q         <= href;
      d_q          <= d;
      we_q         <= wr_fire;
      frame_done_q <= vs_rise & seen_rise_q;
      if (vs_rise) seen_rise_q <= 1'b1;
      if (latch_hi) hi_q <= d_q;
      // hi = {R5, G6[5:3]}, lo = {G6[2:0], B5}; keep the top bits of each channel.
      if (wr_fire) dout_q <= {hi_q[7:4], hi_q[2:0], d_q[7], d_q[4:1]};
      if (ovf_fire) overflow_q <= 1'b1;
      // vsync rise wins over a post-write increment.
      if (vs_rise) begin
        addr_q <= '0;
        full_q <= 1'b0;
      end else if (we_q) begin
        if (addr_q == LastAddr) full_q <= 1'b1;
        else                    addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Directed bench for rgb_frame_writer on a reduced 8x4 frame.
module tb_rgb_frame_writer;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
`ifdef RGB_FRAME_WRITER_DECIMATE_EN
  localparam int unsigned FS = (H / 2) * (V / 2);
`else
  localparam int unsigned FS = H * V;
`endif

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  d = 8'h00;
  logic [18:0] addr;
  logic [11:0] dout;
  logic        we, frame_done, overflow;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_dout[$];

  rgb_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(19)) dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (we) begin
      wq_addr.push_back(32'(addr));
      wq_dout.push_back(32'(dout));
    end
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (wq_addr.size() > i) ? wq_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (wq_dout.size() > i) ? wq_dout[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      href = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge pclk);
    href = 1'b1;
    d    = b;
  endtask

  task automatic end_line();
    idle(5);
  endtask

  task automatic send_line(input int npx, input logic [7:0] hi, input logic [7:0] lo);
    for (int i = 0; i < npx; i++) begin
      send_byte(hi);
      send_byte(lo);
    end
    end_line();
  endtask

  task automatic vs_pulse();
    @(negedge pclk);
    href  = 1'b0;
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(5);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_dout.delete();
  endtask

  initial begin
    int fd0;
    int seq_err;

    // Reset: outputs zero while rst is held.
    idle(3);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    idle(2);

    // No writes before the first vsync falling edge.
    send_line(2, 8'hF8, 8'h00);
    chk("pre_vsync_writes", 32'(wq_addr.size()), 0);

    // First vsync rise after reset does not pulse frame_done.
    vs_pulse();
    chk("first_fd", 32'(fd_cnt), 0);

    // Colour conversion.
    clear_q();
    send_byte(8'hF8); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'hE0);
    send_byte(8'h00); send_byte(8'h1F);
    send_byte(8'hFF); send_byte(8'hFF);
    end_line();
`ifdef RGB_FRAME_WRITER_DECIMATE_EN
    chk("col_n", 32'(wq_addr.size()), 2);
    chk("col_a0", qa(0), 0);
    chk("col_d0", qd(0), 32'hF00);
    chk("col_a1", qa(1), 1);
    chk("col_d1", qd(1), 32'h00F);
`else
    chk("col_n", 32'(wq_addr.size()), 4);
    chk("col_a0", qa(0), 0);
    chk("col_d0", qd(0), 32'hF00);
    chk("col_a1", qa(1), 1);
    chk("col_d1", qd(1), 32'h0F0);
    chk("col_a2", qa(2), 2);
    chk("col_d2", qd(2), 32'h00F);
    chk("col_a3", qa(3), 3);
    chk("col_d3", qd(3), 32'hFFF);
`endif

    // Second vsync rise pulses frame_done and clears addr.
    vs_pulse();
    chk("fd_second", 32'(fd_cnt), 1);
    chk("addr_cleared", 32'(addr), 0);

    // Odd byte count: trailing high byte dropped.
    clear_q();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    end_line();
    chk("odd_n", 32'(wq_addr.size()), 1);
    chk("odd_a0", qa(0), 0);
`ifdef RGB_FRAME_WRITER_DECIMATE_EN
    send_line(1, 8'h12, 8'h34);  // line 1 is skipped when decimating
    chk("dec_line1_n", 32'(wq_addr.size()), 1);
`endif
    send_line(1, 8'hF8, 8'h00);
    chk("odd_next_n", 32'(wq_addr.size()), 2);
    chk("odd_next_a", qa(1), 1);
    chk("odd_next_d", qd(1), 32'hF00);

    // vsync rise coinciding with the low byte drops the pixel.
    vs_pulse();
    clear_q();
    @(negedge pclk); href = 1'b1; d = 8'hF8;
    @(negedge pclk); href = 1'b1; d = 8'h00; vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(5);
    chk("coll_n", 32'(wq_addr.size()), 0);
    chk("coll_addr", 32'(addr), 0);

    // Full frame.
    vs_pulse();
    clear_q();
    for (int l = 0; l < V; l++) begin
      send_line(H, 8'h5A, 8'hC3);
`ifdef RGB_FRAME_WRITER_DECIMATE_EN
      if (l == 0) chk("dec_l0_n", 32'(wq_addr.size()), H / 2);
      if (l == 1) chk("dec_l1_n", 32'(wq_addr.size()), H / 2);
`endif
    end
    chk("full_n", 32'(wq_addr.size()), FS);
    chk("full_last", qa(FS - 1), FS - 1);
    seq_err = 0;
    for (int i = 0; i < int'(FS); i++) begin
      // 5A,C3 -> R=5, G={010,1}=5, B=0001 -> 0x551
      if (qa(i) !== 32'(i) || qd(i) !== 32'h551) seq_err++;
    end
    chk("full_seq", 32'(seq_err), 0);
    fd0 = fd_cnt;
    vs_pulse();
    chk("full_fd", 32'(fd_cnt - fd0), 1);
    chk("full_addr0", 32'(addr), 0);
    chk("full_ovf", 32'(overflow), 0);

    // One line too many: writes stop at the last location, overflow is sticky.
    clear_q();
    for (int l = 0; l < V + 1; l++) send_line(H, 8'hFF, 8'hFF);
    chk("ovf_n", 32'(wq_addr.size()), FS);
    chk("ovf_last", qa(FS - 1), FS - 1);
    chk("ovf_addr_hold", 32'(addr), FS - 1);
    chk("ovf_set", 32'(overflow), 1);
    vs_pulse();
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset clears overflow; writing waits for the next vsync fall.
    @(negedge pclk); rst = 1'b1;
    idle(2);
    chk("ovf_rst", 32'(overflow), 0);
    rst = 1'b0;
    clear_q();
    send_line(2, 8'hF8, 8'h00);
    chk("post_rst_n", 32'(wq_addr.size()), 0);
    vs_pulse();
    send_line(1, 8'h07, 8'hE0);
    chk("resume_n", 32'(wq_addr.size()), 1);
    chk("resume_d", qd(0), 32'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_frame_writer.md
RGB_FRAME_WRITER -- requirements
Module: rgb_frame_writer

Interface
- REQ-001: The block SHALL have a parameter H_ACTIVE, default 640, giving the number of pixels per active line.
- REQ-002: The block SHALL have a parameter V_ACTIVE, default 480, giving the number of active lines per frame.
- REQ-003: The block SHALL have a parameter ADDR_W, default 19, giving the frame-buffer address width.
- REQ-004: The block SHALL have port pclk, input, 1 bit: the single clock, the camera pixel clock; all logic is on its rising edge.
- REQ-005: The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006: The block SHALL have port vsync, input, 1 bit: camera frame sync, high between frames.
- REQ-007: The block SHALL have port href, input, 1 bit: camera line valid, high during active bytes.
- REQ-008: The block SHALL have port d, input, 8 bits: camera data byte, RGB565, two bytes per pixel, high byte first.
- REQ-009: The block SHALL have port addr, output, ADDR_W bits: frame-buffer write address.
- REQ-010: The block SHALL have port dout, output, 12 bits: RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- REQ-011: The block SHALL have port we, output, 1 bit: one-cycle write strobe for addr/dout.
- REQ-012: The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
- REQ-013: The block SHALL have port overflow, output, 1 bit: sticky flag, set when a frame supplies more pixels than the buffer holds.

Function
- REQ-014: The block SHALL register vsync, href and d once before use, and all further timing SHALL be counted from these registered copies.
- REQ-015: The FSM SHALL have four states: SYNC, IDLE, HI, LO.
  - SYNC: wait for a vsync falling edge, then go to IDLE.
  - IDLE: on href high, latch the byte and go to LO.
  - LO: latch the byte, build the pixel, and go to HI if href is still high, otherwise to IDLE.
  - HI: same as IDLE, but only while href is high.
- REQ-016: After reset the FSM SHALL be in SYNC, so no writes occur until the first full frame boundary.
- REQ-017: Pixel conversion SHALL be:
  - hi byte = {R5[4:0], G6[5:3]}; lo byte = {G6[2:0], B5[4:0]}.
  - dout = {R5[4:1], G6[5:2], B5[4:1]}.
- REQ-018: we SHALL assert exactly one cycle after the low byte is sampled, with addr and dout valid in that same cycle.
- REQ-019: After each write, addr SHALL increment by 1.
- REQ-020: addr SHALL clear to 0 on every vsync rising edge.
- REQ-021: If href falls after a high byte with no low byte, that half pixel SHALL be discarded, and neither we nor the addr increment SHALL occur.
- REQ-022: While vsync is high, href SHALL be ignored and the FSM SHALL hold in SYNC.
- REQ-023: frame_done SHALL pulse for one cycle on the vsync rising edge, except for the first vsync rising edge after reset.
- REQ-024: When addr reaches the last valid location (frame size minus 1), further pixels in that frame SHALL be suppressed: we stays low, addr holds, and overflow is set.
- REQ-025: overflow SHALL clear only on rst.
- REQ-026: A vsync rising edge coinciding with the low byte SHALL drop that pixel; the addr clear SHALL take priority over the write.

Reset
- REQ-027: When rst is high on a pclk edge, all outputs SHALL be 0 on the next cycle:
  - addr = 0, dout = 0, we = 0, frame_done = 0, overflow = 0.
  - FSM = SYNC.
- REQ-028: Assertion of rst mid-line SHALL abandon any partial pixel.
- REQ-029: After rst is released, writing SHALL resume only after the next vsync falling edge.

Configuration
- REQ-030: When macro RGB_FRAME_WRITER_DECIMATE_EN is defined, the block SHALL write only even pixels of even lines.
  - A line counter tracks lines; a pixel parity bit tracks pixels.
  - Frame size = (H_ACTIVE/2)*(V_ACTIVE/2) = 76800.
  - Last valid address = 76799.
- REQ-031: When RGB_FRAME_WRITER_DECIMATE_EN is undefined, the block SHALL write every pixel.
  - No line counter is built.
  - Frame size = H_ACTIVE*V_ACTIVE = 307200.
  - Last valid address = 307199.

Verification
- REQ-032: Bench SHALL cover: rst, then vsync pulse, then one line of bytes 0xF8,0x00 -> we pulses with dout = 0xF00 at addr 0; then 0x07,0xE0 -> dout = 0x0F0 at addr 1.
- REQ-033: Bench SHALL cover: bytes 0x00,0x1F -> dout = 0x00F; bytes 0xFF,0xFF -> dout = 0xFFF.
- REQ-034: Bench SHALL cover: a line of 3 bytes (href falls after the odd byte) -> exactly 1 write; the next line starts at addr 1.
- REQ-035: Bench SHALL cover: a full 640x480 frame followed by vsync rising -> 307200 writes, last addr 307199, one frame_done pulse, addr = 0 afterwards, overflow = 0.
- REQ-036: Bench SHALL cover: a frame with 481 lines -> writes stop at addr 307199 and overflow = 1 until rst.
- REQ-037: Bench SHALL cover, with RGB_FRAME_WRITER_DECIMATE_EN defined: a 640x480 frame -> 76800 writes, and line 1 produces no writes.
